// File: rtl/ip_sec_mailbox_writer_pkg.sv
// rtl/ip_sec_mailbox_writer_pkg.sv - shared constants, state encoding and status word helper for the mailbox writer
package ip_sec_mailbox_writer_pkg;

    localparam logic [7:0] STATUS_TAG = 8'hA5;

    localparam int unsigned MBOX_WIN      = 16;
    localparam int unsigned MBOX_BASE_IP1 = 48;
    localparam int unsigned MBOX_BASE_IP2 = 64;
    localparam int unsigned MBOX_BASE_IP3 = 80;
    localparam int unsigned MBOX_BASE_IP4 = 96;
    localparam int unsigned MBOX_BASE_IP5 = 112;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_GAP   = 2'd2
    } mbox_state_t;

    function automatic logic [31:0] status_word(
        input logic [7:0] ip_id,
        input logic [4:0] occ,
        input logic [7:0] seq
    );
        return {STATUS_TAG, ip_id, 3'b000, occ, seq};
    endfunction

endpackage

// File: rtl/ip_sec_mailbox_writer_fifo.sv
// rtl/ip_sec_mailbox_writer_fifo.sv - sec_evt_fifo, synchronous event FIFO with full/empty flags and async clear
module sec_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/ip_sec_mailbox_writer.sv
// rtl/ip_sec_mailbox_writer.sv - posts IP security events and status words into the SPC mailbox window
module ip_sec_mailbox_writer
    import ip_sec_mailbox_writer_pkg::*;
#(
    parameter int unsigned BASE   = MBOX_BASE_IP1,
    parameter int unsigned WIN    = MBOX_WIN,
    parameter int unsigned IP_ID  = 1,
    parameter int unsigned FDEPTH = 4
) (
    input  logic        PHI1,
    input  logic        MASRSTN,
    input  logic        EVT_VALID,
    input  logic [31:0] EVT_DATA,
    output logic        EVT_READY,
    input  logic        SPCDIS,
    input  logic        SPCREQ,
    input  logic        RD_ACK,
    output logic [31:0] DAddrE,
    output logic [31:0] DOutE,
    output logic        DWriteE,
    output logic        IP_EN,
    output logic [4:0]  OCC
);

    localparam logic [31:0] ADDR_FIRST = 32'(BASE);
    localparam logic [31:0] ADDR_LAST  = 32'(BASE + WIN - 1);
    localparam logic [4:0]  OCC_FULL   = 5'(WIN - 1);
    localparam logic [7:0]  ID8        = 8'(IP_ID);

    mbox_state_t state_q;
    mbox_state_t state_d;

    logic [31:0] daddr_q;
    logic [31:0] dout_q;
    logic [4:0]  occ_q;
    logic [4:0]  occ_d;
    logic [7:0]  seq_q;
    logic        pend_q;
    logic        req_q;
    logic        ip_en_q;
    logic        run_q;

    logic        fifo_full;
    logic        fifo_empty;
    logic [31:0] fifo_head;
    logic        fifo_push;
    logic        fifo_pop;

    logic        req_edge;
    logic        can_issue;
    logic        issue;
    logic        in_write;
    logic [31:0] word;
    logic [31:0] addr_next;

    // run_q keeps EVT_READY low while reset is held and until the first edge after release.
    assign EVT_READY = run_q && !SPCDIS && !fifo_full;
    assign fifo_push = EVT_VALID && EVT_READY;
    assign req_edge  = SPCREQ && !req_q;
    assign in_write  = (state_q == ST_WRITE);

    // Status bypasses SPCDIS; FIFO data waits for the disable to drop.
    assign can_issue = (occ_q < OCC_FULL) && (pend_q || (!fifo_empty && !SPCDIS));
    assign fifo_pop  = issue && !pend_q;
    assign word      = pend_q ? status_word(ID8, occ_q, seq_q) : fifo_head;
    assign addr_next = (daddr_q == ADDR_LAST) ? ADDR_FIRST : daddr_q + 32'd1;

    assign DAddrE  = daddr_q;
    assign DOutE   = dout_q;
    assign DWriteE = in_write;
    assign IP_EN   = ip_en_q;
    assign OCC     = occ_q;

    sec_evt_fifo #(
        .DEPTH (FDEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk       (PHI1),
        .resetn    (MASRSTN),
        .push      (fifo_push),
        .push_data (EVT_DATA),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // GAP may issue straight into the next WRITE so back-to-back words land two cycles apart.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (can_issue) begin
                    state_d = ST_WRITE;
                    issue   = 1'b1;
                end
            end
            ST_WRITE: begin
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (can_issue) begin
                    state_d = ST_WRITE;
                    issue   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The word is counted while its strobe is high, so an RD_ACK in that same cycle cancels out.
    always_comb begin
        occ_d = occ_q;
        if (in_write && !RD_ACK) begin
            occ_d = occ_q + 5'd1;
        end else if (!in_write && RD_ACK && (occ_q != 5'd0)) begin
            occ_d = occ_q - 5'd1;
        end
    end

    always_ff @(posedge PHI1 or negedge MASRSTN) begin
        if (!MASRSTN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge PHI1 or negedge MASRSTN) begin
        if (!MASRSTN) begin
            daddr_q <= ADDR_FIRST;
            dout_q  <= 32'd0;
            occ_q   <= 5'd0;
            seq_q   <= 8'd0;
            pend_q  <= 1'b0;
            req_q   <= 1'b0;
            ip_en_q <= 1'b1;
            run_q   <= 1'b0;
        end else begin
            run_q   <= 1'b1;
            req_q   <= SPCREQ;
            ip_en_q <= !SPCDIS;
            occ_q   <= occ_d;
            // Further request edges while a status word is pending fold into that one word.
            pend_q  <= req_edge || (pend_q && !issue);
            if (issue) begin
                daddr_q <= addr_next;
                dout_q  <= word;
                seq_q   <= seq_q + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ip_sec_mailbox_writer.sv
// tb/tb_ip_sec_mailbox_writer.sv - self-checking bench for ip_sec_mailbox_writer
module tb_ip_sec_mailbox_writer;

    logic        PHI1;
    logic        MASRSTN;
    logic        EVT_VALID;
    logic [31:0] EVT_DATA;
    logic        EVT_READY;
    logic        SPCDIS;
    logic        SPCREQ;
    logic        RD_ACK;
    logic [31:0] DAddrE;
    logic [31:0] DOutE;
    logic        DWriteE;
    logic        IP_EN;
    logic [4:0]  OCC;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] wlog_a[$];
    logic [31:0] wlog_d[$];
    int          wlog_c[$];

    logic [31:0] q[$];
    logic [31:0] exp_addr;
    int          occ_m;
    logic        dis_prev;

    logic [31:0] w[16];
    logic [31:0] f1, f2, g0, g1, g2, h, k1, k2;
    int          c_push;
    int          base_n;

    ip_sec_mailbox_writer dut (
        .PHI1      (PHI1),
        .MASRSTN   (MASRSTN),
        .EVT_VALID (EVT_VALID),
        .EVT_DATA  (EVT_DATA),
        .EVT_READY (EVT_READY),
        .SPCDIS    (SPCDIS),
        .SPCREQ    (SPCREQ),
        .RD_ACK    (RD_ACK),
        .DAddrE    (DAddrE),
        .DOutE     (DOutE),
        .DWriteE   (DWriteE),
        .IP_EN     (IP_EN),
        .OCC       (OCC)
    );

    initial PHI1 = 1'b0;
    always #5 PHI1 = ~PHI1;

    always @(posedge PHI1) cyc <= cyc + 1;

    always @(negedge PHI1) begin
        if (DWriteE === 1'b1) begin
            wlog_a.push_back(DAddrE);
            wlog_d.push_back(DOutE);
            wlog_c.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PHI1);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        MASRSTN = 1'b0;
        tick();
        tick();
        MASRSTN = 1'b1;
        tick();
    endtask

    task automatic ack();
        RD_ACK = 1'b1;
        tick();
        RD_ACK = 1'b0;
    endtask

    task automatic push_evt(input logic [31:0] d);
        bit ok;
        ok        = 1'b0;
        EVT_VALID = 1'b1;
        EVT_DATA  = d;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge PHI1);
            if (EVT_READY === 1'b1) ok = 1'b1;
            @(posedge PHI1);
            #1;
        end
        EVT_VALID = 1'b0;
        if (!ok) chk("push_timeout", 32'(ok), 32'd1);
    endtask

    // Reference: q mirrors the FIFO contents, exp_addr the last window address, occ_m the occupancy.
    task automatic rnd_cycle(input logic v, input logic [31:0] d, input logic a, input logic dis);
        logic [31:0] na;
        logic        er;
        EVT_VALID = v;
        EVT_DATA  = d;
        RD_ACK    = a;
        SPCDIS    = dis;
        @(negedge PHI1);
        chk("r_occ", 32'(OCC), 32'(occ_m));
        chk("r_ip_en", 32'(IP_EN), 32'(!dis_prev));
        if (DWriteE === 1'b1) begin
            na = (exp_addr == 32'd63) ? 32'd48 : exp_addr + 32'd1;
            chk("r_addr", DAddrE, na);
            exp_addr = na;
            chk("r_wr_room", 32'(occ_m < 15), 32'd1);
            chk("r_wr_dis", 32'(dis_prev), 32'd0);
            chk("r_wr_has_data", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) chk("r_data", DOutE, q.pop_front());
        end
        er = !dis && (q.size() < 4);
        chk("r_ready", 32'(EVT_READY), 32'(er));
        if (v && er) q.push_back(d);
        if (DWriteE === 1'b1 && !a) occ_m++;
        else if (DWriteE !== 1'b1 && a && occ_m > 0) occ_m--;
        dis_prev = dis;
        @(posedge PHI1);
        #1;
    endtask

    initial begin
        MASRSTN   = 1'b0;
        EVT_VALID = 1'b0;
        EVT_DATA  = 32'd0;
        SPCDIS    = 1'b0;
        SPCREQ    = 1'b0;
        RD_ACK    = 1'b0;
        idle(3);

        // Reset values
        chk("rst_addr", DAddrE, 32'd48);
        chk("rst_dout", DOutE, 32'd0);
        chk("rst_dwrite", 32'(DWriteE), 32'd0);
        chk("rst_ready", 32'(EVT_READY), 32'd0);
        chk("rst_ip_en", 32'(IP_EN), 32'd1);
        chk("rst_occ", 32'(OCC), 32'd0);
        MASRSTN = 1'b1;
        tick();
        chk("run_ready", 32'(EVT_READY), 32'd1);

        // Two events: 49/50, two cycles apart, one cycle after the push
        wlog_a.delete(); wlog_d.delete(); wlog_c.delete();
        push_evt(32'h11);
        c_push = cyc;
        push_evt(32'h22);
        idle(6);
        chk("t1_count", 32'(wlog_a.size()), 32'd2);
        if (wlog_a.size() == 2) begin
            chk("t1_a0", wlog_a[0], 32'd49);
            chk("t1_d0", wlog_d[0], 32'h11);
            chk("t1_a1", wlog_a[1], 32'd50);
            chk("t1_d1", wlog_d[1], 32'h22);
            chk("t1_gap", 32'(wlog_c[1] - wlog_c[0]), 32'd2);
            chk("t1_latency", 32'(wlog_c[0] - c_push), 32'd1);
        end
        chk("t1_occ", 32'(OCC), 32'd2);

        // Fill the window: 15 writes to 49..63, 16th waits, one RD_ACK wraps to 48
        do_reset();
        wlog_a.delete(); wlog_d.delete(); wlog_c.delete();
        for (int i = 0; i < 16; i++) begin
            w[i] = $urandom;
            push_evt(w[i]);
        end
        idle(8);
        chk("t2_count15", 32'(wlog_a.size()), 32'd15);
        for (int i = 0; i < 15 && i < wlog_a.size(); i++) begin
            chk("t2_addr", wlog_a[i], 32'(49 + i));
            chk("t2_data", wlog_d[i], w[i]);
        end
        chk("t2_occ_full", 32'(OCC), 32'd15);
        chk("t2_ready", 32'(EVT_READY), 32'd1);
        ack();
        idle(4);
        chk("t2_count16", 32'(wlog_a.size()), 32'd16);
        if (wlog_a.size() == 16) begin
            chk("t2_wrap_addr", wlog_a[15], 32'd48);
            chk("t2_wrap_data", wlog_d[15], w[15]);
        end
        chk("t2_occ_after", 32'(OCC), 32'd15);

        // SPCDIS with two words held in the FIFO
        f1 = $urandom;
        f2 = $urandom;
        push_evt(f1);
        push_evt(f2);
        SPCDIS = 1'b1;
        #1;
        chk("t3_ready_dis", 32'(EVT_READY), 32'd0);
        chk("t3_ip_en_same", 32'(IP_EN), 32'd1);
        #1;
        tick();
        chk("t3_ip_en_late", 32'(IP_EN), 32'd0);
        ack();
        ack();
        idle(6);
        chk("t3_no_write", 32'(wlog_a.size()), 32'd16);
        chk("t3_occ_dis", 32'(OCC), 32'd13);
        SPCDIS = 1'b0;
        idle(8);
        chk("t3_ip_en_back", 32'(IP_EN), 32'd1);
        chk("t3_count", 32'(wlog_a.size()), 32'd18);
        if (wlog_a.size() == 18) begin
            chk("t3_a0", wlog_a[16], 32'd49);
            chk("t3_d0", wlog_d[16], f1);
            chk("t3_a1", wlog_a[17], 32'd50);
            chk("t3_d1", wlog_d[17], f2);
        end
        chk("t3_occ", 32'(OCC), 32'd15);

        // Two request edges under SPCDIS while full: one merged status word
        SPCDIS = 1'b1;
        SPCREQ = 1'b1; tick();
        SPCREQ = 1'b0; tick();
        SPCREQ = 1'b1; tick();
        SPCREQ = 1'b0;
        idle(3);
        chk("t4_blocked", 32'(wlog_a.size()), 32'd18);
        ack();
        idle(6);
        chk("t4_count", 32'(wlog_a.size()), 32'd19);
        if (wlog_a.size() == 19) begin
            chk("t4_st_addr", wlog_a[18], 32'd51);
            chk("t4_st_data", wlog_d[18], 32'hA5010E12);
        end
        ack();
        idle(6);
        chk("t4_merged", 32'(wlog_a.size()), 32'd19);
        chk("t4_occ", 32'(OCC), 32'd14);

        // Status ahead of FIFO data
        SPCDIS = 1'b0;
        g0 = $urandom; g1 = $urandom; g2 = $urandom;
        push_evt(g0);
        push_evt(g1);
        push_evt(g2);
        SPCDIS = 1'b1;
        repeat (4) ack();
        idle(2);
        SPCREQ = 1'b1;
        tick();
        SPCDIS = 1'b0;
        idle(8);
        SPCREQ = 1'b0;
        chk("t4b_count", 32'(wlog_a.size()), 32'd23);
        if (wlog_a.size() == 23) begin
            chk("t4b_g0", wlog_d[19], g0);
            chk("t4b_st_addr", wlog_a[20], 32'd53);
            chk("t4b_st_data", wlog_d[20], 32'hA5010B14);
            chk("t4b_g1", wlog_d[21], g1);
            chk("t4b_g2_addr", wlog_a[22], 32'd55);
            chk("t4b_g2", wlog_d[22], g2);
        end
        chk("t4b_occ", 32'(OCC), 32'd14);

        // RD_ACK during WRITE, then RD_ACK at zero
        repeat (4) ack();
        h = $urandom;
        push_evt(h);
        tick();
        chk("t5_in_write", 32'(DWriteE), 32'd1);
        chk("t5_addr", DAddrE, 32'd56);
        ack();
        idle(2);
        chk("t5_occ_same", 32'(OCC), 32'd10);
        repeat (10) ack();
        chk("t5_occ_zero", 32'(OCC), 32'd0);
        ack();
        idle(2);
        chk("t5_occ_sat", 32'(OCC), 32'd0);

        // Reset in the middle of a WRITE
        k1 = $urandom; k2 = $urandom;
        push_evt(k1);
        idle(4);
        push_evt(k2);
        tick();
        chk("t6_in_write", 32'(DWriteE), 32'd1);
        #2;
        MASRSTN = 1'b0;
        #1;
        chk("t6_dwrite", 32'(DWriteE), 32'd0);
        chk("t6_addr", DAddrE, 32'd48);
        chk("t6_occ", 32'(OCC), 32'd0);
        chk("t6_dout", DOutE, 32'd0);
        base_n = wlog_a.size();
        tick();
        MASRSTN = 1'b1;
        tick();
        idle(6);
        chk("t6_fifo_empty", 32'(wlog_a.size()), 32'(base_n));
        SPCREQ = 1'b1;
        idle(4);
        SPCREQ = 1'b0;
        chk("t6_st_count", 32'(wlog_a.size()), 32'(base_n + 1));
        if (wlog_a.size() == base_n + 1) begin
            chk("t6_st_addr", wlog_a[base_n], 32'd49);
            chk("t6_st_data", wlog_d[base_n], 32'hA5010000);
        end

        // Randomized traffic against the reference model
        do_reset();
        q.delete();
        exp_addr = 32'd48;
        occ_m    = 0;
        dis_prev = 1'b0;
        begin
            logic dis;
            dis = 1'b0;
            for (int i = 0; i < 400; i++) begin
                if (i % 25 == 0) dis = ($urandom_range(0, 2) == 0);
                rnd_cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 2) == 0), dis);
            end
        end
        for (int i = 0; i < 100; i++) begin
            rnd_cycle(1'b0, 32'd0, 1'b1, 1'b0);
        end
        chk("r_drained", 32'(q.size()), 32'd0);
        chk("r_occ_end", 32'(OCC), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
